// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 responder with a 4-byte register file
// All SPI pins are oversampled in the clk domain; register 3 is a read-only write counter.
module spi_reg_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG0_RESET  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] reg0_out,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE,
    ST_WAIT_CS
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] vld_sync;
  logic                   sclk_d;
  logic                   armed;

  logic       sclk_s, cs_s, mosi_s, vld_s;
  logic       rise, fall;

  logic [3:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] shift_out;
  logic       rw;
  logic [1:0] addr;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       miso_q;

  logic [7:0] reg0, reg1, reg2, wr_count;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign vld_s  = vld_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  // vld_sync marks when the synchronizer holds real pin samples rather than reset fill
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      vld_sync  <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      // A frame cut by reset must not resume: wait for a genuine cs_n high first
      if (vld_s && cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (armed && !cs_s) state_n = ST_CMD;
      end
      ST_CMD: begin
        if (cs_s) state_n = ST_IDLE;
        else if (rise && bit_cnt == 4'd7) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (cs_s) state_n = ST_IDLE;
        else if (rise && bit_cnt == 4'd15) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_WAIT_CS;
      end
      ST_WAIT_CS: begin
        if (cs_s) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign rd_addr = {shift_in[0], mosi_s};

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      2'd0:    rd_data = reg0;
      2'd1:    rd_data = reg1;
      2'd2:    rd_data = reg2;
      default: rd_data = wr_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      rw        <= 1'b0;
      addr      <= 2'd0;
      miso_q    <= 1'b0;
      reg0      <= REG0_RESET;
      reg1      <= 8'h00;
      reg2      <= 8'h00;
      wr_count  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= 4'd0;
          miso_q  <= 1'b0;
        end
        ST_CMD, ST_DATA: begin
          if (!cs_s && rise) begin
            shift_in <= {shift_in[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 4'd1;
            if (state == ST_CMD && bit_cnt == 4'd7) begin
              rw        <= shift_in[6];
              addr      <= rd_addr;
              shift_out <= rd_data;
            end
          end
          if (state == ST_DATA && !cs_s && fall && rw) begin
            miso_q    <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (!rw) begin
            case (addr)
              2'd0:    reg0 <= shift_in;
              2'd1:    reg1 <= shift_in;
              2'd2:    reg2 <= shift_in;
              default: ;
            endcase
            wr_count <= wr_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_miso_oe = (state != ST_IDLE) && !cs_s;
  assign spi_miso    = spi_miso_oe & miso_q;
  assign frame_done  = (state == ST_DONE);
  assign reg0_out    = reg0;

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 target (responder) for the tt_um_semis_UABC_2024 pin interface.
- An external initiator, such as the cocotb bench or an off-chip MCU, drives SCLK/CS_N/MOSI on uio_in pins and reads MISO on a uio_out pin.
- Provides a 4-byte register file. Register 0 is exported to drive uo_out.
- All SPI inputs are oversampled in the clk domain. There is no second clock.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sclk/cs_n/mosi before edge detection (legal values 2..3).
- REG0_RESET, 8'h00, reset value of register 0.

Ports:
- clk  input  1  system clock (TT clk).
- rst  input  1  synchronous, active-high reset. Top level drives ~rst_n.
- spi_sclk  input  1  SPI clock from initiator (uio_in[0]). Idle low.
- spi_cs_n  input  1  chip select, active low (uio_in[1]).
- spi_mosi  input  1  initiator data out (uio_in[2]).
- spi_miso  output  1  responder data out (uio_out[3]).
- spi_miso_oe  output  1  output enable for the MISO pin (uio_oe[3]).
- reg0_out  output  8  current value of register 0 (to uo_out).
- frame_done  output  1  one-cycle pulse when a complete 16-bit frame has been accepted.

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - spi_miso=0, spi_miso_oe=0, frame_done=0.
  - reg0=REG0_RESET, reg1=reg2=0, wr_count(reg3)=0.
  - FSM=IDLE, bit counter=0, synchronizers cleared to sclk=0, cs_n=1.
- Synchronisation and edge detection:
  - Inputs pass through SYNC_STAGES flip-flops.
  - rise/fall = edge detect on the synchronized sclk.
  - Required initiator timing: SCLK high and low phases each >= 4 clk.
- Frame format: 16 bits, MSB first.
  - Byte 0 = {RW, 5'b0, ADDR[1:0]}; RW=1 means read, 0 means write.
  - Byte 1 = write data, or read data returned on MISO.
- MOSI is sampled on the synchronized sclk rise. MISO updates on the synchronized sclk fall.
- FSM states and transitions:
  - IDLE: wait for synchronized cs_n=0 → CMD, bit counter=0.
  - CMD: shift in 8 bits on rise. On the 8th rise, latch RW/ADDR.
    - If read, load shift_out = reg[ADDR] → DATA.
  - DATA:
    - Read: on each fall, spi_miso = shift_out[7] and shift_out shifts left. The first fall after the 8th rise presents bit 7.
    - Write: shift in 8 bits on rise.
    - On the 16th rise → DONE.
  - DONE: the clk cycle after the 16th rise:
    - write: reg[ADDR] <= data, except ADDR=3, which is ignored.
    - write_count <= write_count + 1 (8-bit, wraps 255→0) for every write frame, including ADDR=3.
    - frame_done=1 for exactly 1 cycle.
    - Then → WAIT_CS.
  - WAIT_CS: ignore all sclk edges until synchronized cs_n=1 → IDLE.
- Register 3 is read-only and returns wr_count.
- spi_miso_oe = 1 while synchronized cs_n=0 (any state except IDLE). Otherwise spi_miso_oe=0 and spi_miso=0.
- spi_miso = 0 during the CMD byte and during DATA of a write frame.
- Abort: cs_n deasserts in CMD or DATA (before the 16th rise):
  - return to IDLE;
  - no register write, no wr_count increment, no frame_done.
- Extra bits: sclk edges after the 16th rise with cs_n low are ignored, with no second frame. A new frame requires cs_n high for >= 1 synchronized sample.
- Glitch rule: a sclk edge in the same synchronized cycle as the cs_n fall is not counted.
- Mid-operation reset: rst during any state immediately restores all reset values. The partial frame is discarded, and an initiator still clocking is ignored until cs_n is cycled high.
- Reading register 0 returns the reg0_out value at the 8th rise. A write in a previous frame is visible.

Test Plan:
- Reset: assert rst 2 cycles → reg0_out=00, spi_miso_oe=0, frame_done=0. Read addr 3 → 00.
- Write 0xA5 to addr 0, frame 0x00 0xA5, sclk half-period 5 clk → frame_done pulses once, reg0_out=A5. Then read 0x80 → MISO returns A5 on bits 8..15.
- Write 0x3C to addr 2, read back with 0x82 → 3C. Read 0x83 → wr_count=02. Write 0xFF to addr 3 → value is not stored, wr_count=03.
- Abort: send 0x01, then 4 bits of 0xF0 and raise cs_n → reg1 unchanged (00), no frame_done, wr_count unchanged. The next full frame works.
- 24 sclk pulses in one cs_n window writing 0x00 0x11 0x22 → reg0=11, exactly one frame_done. 256 write frames → wr_count wraps to 00.
- Assert rst at bit 10 of a write frame → registers reset, no write. Finish clocking with cs_n low, then cs_n high, then a new frame → normal response.
